// File: rtl/vga_scan_driver_if.sv
// Pixel source bus between the VGA scan driver and the graphics engine.
// The driver (master) strobes VGA_ready; the engine (slave) returns data.
interface vga_scan_driver_if;
  logic        VGA_ready;
  logic [23:0] color;
  logic [18:0] pixel_address;

  modport master (
    output VGA_ready,
    input  color,
    input  pixel_address
  );

  modport slave (
    input  VGA_ready,
    output color,
    output pixel_address
  );
endinterface

// File: rtl/vga_scan_driver.sv
// 640x480@60 VGA scan driver with prefetching pixel FIFO.
// Optional macro VGA_ADDR_CHECK_EN enables pixel_address sequence checking.
module vga_scan_driver #(
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PIX_DIV      = 2
) (
  input  logic              clk,
  input  logic              rst,
  vga_scan_driver_if.master src,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank_n,
  output logic              frame_start,
  output logic              underflow,
  output logic              addr_error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);
  localparam logic [23:0] MAGENTA = 24'hFF00FF;

  logic [1:0]  div_q, div_d;
  logic        tick;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        s_v_q, s_vis_q, s_hs_q;
  logic        s_vs_q, s_fs_q;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [4:0]  outst_q, outst_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [23:0] mem_q [FIFO_DEPTH];
  logic [5:0]  occ;
  logic        ready, push, empty;
  logic        pop_req, bypass;
  logic        wr_en, rd_en, pop_ok;
  logic [23:0] push_col, head;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, vs_q, blank_q;
  logic        fs_q, unf_q;

  assign tick = (div_q == 2'd0);
  assign occ = 6'(cnt_q) + 6'(outst_q);
  assign ready = rst & (occ < 6'(FIFO_DEPTH));
  assign src.VGA_ready = ready;
  assign push = pipe_q[READ_LATENCY-1];
  assign empty = (cnt_q == '0);
  assign pop_req = s_v_q & s_vis_q;
  assign bypass = empty & push & pop_req;
  assign wr_en = push & ~bypass;
  assign rd_en = pop_req & ~empty;
  assign pop_ok = rd_en | bypass;
  assign head = empty ? push_col : mem_q[rd_q];

  // Next-state for divider, raster counters and request tracking
  always_comb begin
    div_d = (div_q == DIV_LAST) ? 2'd0 : div_q + 2'd1;
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      h_d = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
      if (h_q == 10'd799)
        v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
    end
    pipe_d = '0;
    pipe_d[0] = ready;
    for (int i = 1; i < READ_LATENCY; i++)
      pipe_d[i] = pipe_q[i-1];
    outst_d = outst_q + 5'(ready) - 5'(push);
    cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    rgb_d = 24'h0;
    if (s_vis_q)
      rgb_d = pop_ok ? head : MAGENTA;
  end

  // Timing, request pipeline and FIFO pointer state
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q   <= 2'd0;
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      pipe_q  <= '0;
      outst_q <= 5'd0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pipe_q  <= pipe_d;
      outst_q <= outst_d;
      cnt_q   <= cnt_d;
      if (wr_en)
        wr_q <= wr_q + AW'(1);
      if (rd_en)
        rd_q <= rd_q + AW'(1);
    end
  end

  // FIFO storage; stale entries are masked by the pointers
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_q] <= push_col;
  end

  // Raster attributes latched on the tick, emitted one clk later
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_v_q   <= 1'b0;
      s_vis_q <= 1'b0;
      s_hs_q  <= 1'b1;
      s_vs_q  <= 1'b1;
      s_fs_q  <= 1'b0;
    end else begin
      s_v_q <= tick;
      if (tick) begin
        s_vis_q <= (h_q < 10'd640) && (v_q < 10'd480);
        s_hs_q  <= !((h_q >= 10'd656) && (h_q <= 10'd751));
        s_vs_q  <= !((v_q == 10'd490) || (v_q == 10'd491));
        s_fs_q  <= (h_q == 10'd0) && (v_q == 10'd0);
      end
    end
  end

  // Registered video outputs and sticky underflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_q   <= 24'h0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (s_v_q) begin
        rgb_q   <= rgb_d;
        hs_q    <= s_hs_q;
        vs_q    <= s_vs_q;
        blank_q <= s_vis_q;
        fs_q    <= s_fs_q;
        if (pop_req && !pop_ok)
          unf_q <= 1'b1;
      end
    end
  end

`ifdef VGA_ADDR_CHECK_EN
  logic [18:0] exp_q, exp_d, base;
  logic        mism, err_q;

  assign mism = (src.pixel_address != exp_q);
  assign push_col = mism ? 24'h0 : src.color;
  assign base = mism ? src.pixel_address : exp_q;
  assign exp_d = (base == 19'h4AFFF) ? 19'h0 : base + 19'h1;
  assign addr_error = err_q;

  // Expected address tracks pushes and resyncs after a mismatch
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q <= 19'h0;
      err_q <= 1'b0;
    end else if (push) begin
      exp_q <= exp_d;
      if (mism)
        err_q <= 1'b1;
    end
  end
`else
  logic unused_addr;

  assign unused_addr = ^src.pixel_address;
  assign push_col = src.color;
  assign addr_error = 1'b0;
`endif

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign vga_blank_n = blank_q;
  assign frame_start = fs_q;
  assign underflow   = unf_q;
endmodule

// File: tb/tb_vga_scan_driver.sv
// Self-checking bench for vga_scan_driver: raster model, ideal source,
// long-latency underflow instance and mid-frame reset.
module tb_vga_scan_driver;
  localparam int PD  = 2;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  vga_scan_driver_if sif ();
  vga_scan_driver_if sif8 ();

  logic [7:0] r, g, b, r8, g8, b8;
  logic hs, vs, bl, fs, unf, aerr;
  logic hs8, vs8, bl8, fs8, unf8, aerr8;

  always #5 clk = ~clk;

  vga_scan_driver dut (
    .clk(clk), .rst(rst), .src(sif.master),
    .vga_r(r), .vga_g(g), .vga_b(b),
    .vga_hsync(hs), .vga_vsync(vs),
    .vga_blank_n(bl), .frame_start(fs),
    .underflow(unf), .addr_error(aerr)
  );

  vga_scan_driver #(.READ_LATENCY(8)) dut8 (
    .clk(clk), .rst(rst), .src(sif8.master),
    .vga_r(r8), .vga_g(g8), .vga_b(b8),
    .vga_hsync(hs8), .vga_vsync(vs8),
    .vga_blank_n(bl8), .frame_start(fs8),
    .underflow(unf8), .addr_error(aerr8)
  );

  // Ideal source: the n-th request is answered LAT clk later
  initial begin
    logic [8:0] hist;
    int n;
    int a;
    hist = '0;
    n = 0;
    sif.color = 24'h0;
    sif.pixel_address = 19'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hist = '0;
        n = 0;
      end else begin
        hist = {hist[7:0], sif.VGA_ready};
        if (hist[LAT]) begin
`ifdef VGA_ADDR_CHECK_EN
          a = (n < 4) ? n : n + 1;
`else
          a = n;
`endif
          sif.pixel_address = 19'(a);
          sif.color = 24'(a);
          n = (n == 307199) ? 0 : n + 1;
        end else begin
          sif.pixel_address = 19'($urandom);
          sif.color = 24'($urandom);
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Expected {rgb,hs,vs,blank,fs} c clk after reset release
  function automatic logic [27:0] model(input int c);
    int k, h, v, idx;
    logic [23:0] rgb;
    logic vis, fsx;
    if (c < 2) return {24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    k = (c - 2) / PD;
    h = k % 800;
    v = (k / 800) % 525;
    vis = (h < 640) && (v < 480);
    idx = v * 640 + h;
`ifdef VGA_ADDR_CHECK_EN
    if (idx == 4) idx = 0;
    else if (idx > 4) idx = idx + 1;
`endif
    rgb = vis ? 24'(idx) : 24'h0;
    fsx = (h == 0) && (v == 0) && ((c - 2) % PD == 0);
    return {rgb, !(h >= 656 && h <= 751),
            !(v == 490 || v == 491), vis, fsx};
  endfunction

  task automatic chk_reset();
    chk("rst_ready", 32'(sif.VGA_ready), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    chk("rst_hs", 32'(hs), 32'd1);
    chk("rst_vs", 32'(vs), 32'd1);
    chk("rst_blank", 32'(bl), 32'd0);
    chk("rst_fs", 32'(fs), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    chk("rst_aerr", 32'(aerr), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 chk_reset();
    end
    rst = 1'b1;
  endtask

  bit seen_mag8;

  task automatic run(input int n);
    logic [27:0] e;
    logic prev_hs;
    int last_fall;
    prev_hs = 1'b1;
    last_fall = -1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      e = model(c);
      if (c == 0) begin
        chk("ready_first", 32'(sif.VGA_ready), 32'd1);
        chk("h0", 32'(dut.h_q), 32'd0);
        chk("v0", 32'(dut.v_q), 32'd0);
        chk("fifo_empty", 32'(dut.cnt_q), 32'd0);
        chk("outst0", 32'(dut.outst_q), 32'd0);
      end
      chk("rgb", 32'({r, g, b}), 32'(e[27:4]));
      chk("hsync", 32'(hs), 32'(e[3]));
      chk("vsync", 32'(vs), 32'(e[2]));
      chk("blank_n", 32'(bl), 32'(e[1]));
      chk("frame_start", 32'(fs), 32'(e[0]));
      chk("underflow", 32'(unf), 32'd0);
`ifndef VGA_ADDR_CHECK_EN
      chk("addr_error", 32'(aerr), 32'd0);
`endif
      if (c == 2)
        chk("l8_first_pix", 32'({r8, g8, b8}),
            32'h00FF00FF);
      if ({r8, g8, b8} == 24'hFF00FF) seen_mag8 = 1'b1;
      if (prev_hs && !hs) begin
        if (last_fall >= 0)
          chk("hs_period", 32'(c - last_fall), 32'd1600);
        last_fall = c;
      end
      if (!prev_hs && hs && last_fall >= 0)
        chk("hs_low", 32'(c - last_fall), 32'd192);
      prev_hs = hs;
    end
  endtask

  initial begin
    int n1;
    seen_mag8 = 1'b0;
    sif8.color = 24'h00ABCD;
    sif8.pixel_address = 19'h0;
    do_reset();
    n1 = $urandom_range(3400, 6000);
    run(n1);
    chk("l8_underflow", 32'(unf8), 32'd1);
    chk("l8_magenta", 32'(seen_mag8), 32'd1);
`ifdef VGA_ADDR_CHECK_EN
    chk("addr_error_set", 32'(aerr), 32'd1);
`endif
    do_reset();
    run(3300 + $urandom_range(0, 200));
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
